// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared definitions for the keypad event path.
// Holds the key-code width, the packed event entry and the
// long-press duration helper used by key_event_fifo.
package key_evt_pkg;

    localparam int KEY_CODE_W = 4;

    // One queued key event: key index plus long-press flag
    typedef struct packed {
        logic [KEY_CODE_W-1:0] code;
        logic                  is_long;
    } key_evt_t;

    // Number of clk cycles a key must be held to count as a long press
    function automatic int long_cycles(input int clk_hz, input int long_ms);
        return (clk_hz / 1000) * long_ms;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: small first-word-fall-through FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate count. A pop while full frees the slot for a push in
// the same cycle; a pop while empty is ignored.
module key_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [W-1:0] mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    // Advance read/write pointers on accepted pop/push
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage write; contents are don't-care until a slot is pushed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/key_event_fifo.sv
// key_event_fifo: turns debounced key levels into queued key events.
// Press edges set per-key pending bits; a lowest-index-first arbiter moves
// them into a FWFT FIFO drained by a valid/ready consumer. A second press of
// a still-pending key is dropped and flagged on overflow.
// Optional long-press tracker enabled by defining KEY_EVT_LONGPRESS_EN.
module key_event_fifo
    import key_evt_pkg::*;
#(
    parameter int NKEYS   = 16,
    parameter int CLK_HZ  = 50_000_000,
    parameter int LONG_MS = 1000,
    parameter int DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [NKEYS-1:0]      key_lvl,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [KEY_CODE_W-1:0] evt_code,
    output logic                  evt_long,
    output logic                  overflow
);

`ifdef KEY_EVT_LONGPRESS_EN
    localparam int ENTRY_W = $bits(key_evt_t);
`else
    localparam int ENTRY_W = KEY_CODE_W;
`endif

    logic [NKEYS-1:0]      key_q_reg;
    logic [NKEYS-1:0]      pending_reg;
    logic [NKEYS-1:0]      press;
    logic [NKEYS-1:0]      pend_lowest;
    logic [NKEYS-1:0]      pushed_mask;
    logic [KEY_CODE_W-1:0] pend_idx;
    logic [KEY_CODE_W-1:0] push_code;
    logic                  push_en;
    logic                  can_accept;
    logic                  drop_short;
    logic                  drop_long;
    logic                  overflow_reg;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    push_data;
    logic [ENTRY_W-1:0]    fifo_head;

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_edge
            assign press[gi] = key_lvl[gi] & ~key_q_reg[gi];
        end
    endgenerate

    assign pend_lowest = pending_reg & (~pending_reg + 1'b1);
    assign can_accept  = ~fifo_full | (evt_valid & evt_ready);
    assign drop_short  = |(press & pending_reg & ~pushed_mask);

    // Encode the lowest set pending bit as a key index
    always_comb begin
        pend_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pending_reg[i]) pend_idx = i[KEY_CODE_W-1:0];
        end
    end

`ifdef KEY_EVT_LONGPRESS_EN
    localparam int LONG_CYCLES = long_cycles(CLK_HZ, LONG_MS);
    localparam int CNT_W       = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [KEY_CODE_W-1:0] trk_key_reg;
    logic [KEY_CODE_W-1:0] long_key_reg;
    logic [KEY_CODE_W-1:0] press_idx;
    logic [CNT_W-1:0]      trk_cnt_reg;
    logic                  trk_act_reg;
    logic                  long_pend_reg;
    logic                  trk_held;
    logic                  threshold;
    logic                  long_take;
    logic                  push_long;
    key_evt_t              push_evt;
    key_evt_t              head_evt;

    assign trk_held  = key_lvl[trk_key_reg];
    assign threshold = trk_act_reg & trk_held & (trk_cnt_reg == CNT_LAST);
    assign drop_long = threshold & long_pend_reg & ~long_take;

    // Highest-index key pressed this cycle becomes the tracked key
    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (press[i]) press_idx = i[KEY_CODE_W-1:0];
        end
    end

    // Track hold time of the most recently pressed key and latch long events
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            trk_key_reg   <= '0;
            trk_cnt_reg   <= '0;
            trk_act_reg   <= 1'b0;
            long_pend_reg <= 1'b0;
            long_key_reg  <= '0;
        end else begin
            if (|press) begin
                trk_key_reg <= press_idx;
                trk_cnt_reg <= '0;
                trk_act_reg <= 1'b1;
            end else if (trk_act_reg) begin
                if (!trk_held) begin
                    trk_act_reg <= 1'b0;
                    trk_cnt_reg <= '0;
                end else if (trk_cnt_reg == CNT_LAST) begin
                    trk_act_reg <= 1'b0;
                end else begin
                    trk_cnt_reg <= trk_cnt_reg + 1'b1;
                end
            end
            if (threshold && (!long_pend_reg || long_take)) begin
                long_pend_reg <= 1'b1;
                long_key_reg  <= trk_key_reg;
            end else if (long_take) begin
                long_pend_reg <= 1'b0;
            end
        end
    end
`else
    assign drop_long = 1'b0;
`endif

    // Arbiter: long event first, then the lowest-index pending press
    always_comb begin
        push_en     = 1'b0;
        push_code   = '0;
        pushed_mask = '0;
`ifdef KEY_EVT_LONGPRESS_EN
        push_long   = 1'b0;
        long_take   = 1'b0;
        if (can_accept && long_pend_reg) begin
            push_en   = 1'b1;
            push_code = long_key_reg;
            push_long = 1'b1;
            long_take = 1'b1;
        end else
`endif
        if (can_accept && (|pending_reg)) begin
            push_en     = 1'b1;
            push_code   = pend_idx;
            pushed_mask = pend_lowest;
        end
    end

    // Edge history, pending presses and the overflow pulse
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            key_q_reg    <= '0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            key_q_reg    <= key_lvl;
            pending_reg  <= (pending_reg & ~pushed_mask) | press;
            overflow_reg <= drop_short | drop_long;
        end
    end

`ifdef KEY_EVT_LONGPRESS_EN
    assign push_evt  = '{code: push_code, is_long: push_long};
    assign push_data = push_evt;
    assign head_evt  = fifo_head;
    assign evt_code  = fifo_empty ? '0 : head_evt.code;
    assign evt_long  = ~fifo_empty & head_evt.is_long;
`else
    assign push_data = push_code;
    assign evt_code  = fifo_empty ? '0 : fifo_head;
    assign evt_long  = 1'b0;
`endif

    assign evt_valid = ~fifo_empty;
    assign overflow  = overflow_reg;

    key_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push_en),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (evt_valid & evt_ready),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule
